hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_ctrl.sv | 116 +++++++++++
 tb/tb_hex_display_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_ctrl.sv
// Binary-to-BCD (double-dabble) display controller driving four 7-seg digits through a shared decoder.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_display_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] in_value,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [4:0] seg_val,
  input  logic [6:0] seg_leds,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       busy,
  output logic       done
);

  localparam int NUM_DIG = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DRIVE   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [9:0]                  shift_q, shift_d;
  logic [NUM_DIG-1:0][3:0]     bcd_q, bcd_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [NUM_DIG-1:0][6:0]     hex_q, hex_d;
  logic [NUM_DIG-1:0][3:0]     bcd_adj;
  logic [3:0]                  cur_nib;
  logic                        blank_dig;

  // add-3 correction on every nibble before the shift
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_adj
    assign bcd_adj[i] = (bcd_q[i] >= 4'd5) ? bcd_q[i] + 4'd3 : bcd_q[i];
  end

  assign cur_nib = bcd_q[cnt_q[1:0]];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIG-1:0] zero_from;
  assign zero_from[NUM_DIG-1] = (bcd_q[NUM_DIG-1] == 4'd0);
  for (genvar i = 0; i < NUM_DIG-1; i++) begin : g_zero
    assign zero_from[i] = (bcd_q[i] == 4'd0) && zero_from[i+1];
  end
  // ones digit is never blanked so a value of 0 still shows "0"
  assign blank_dig = (cnt_q[1:0] != 2'd0) && zero_from[cnt_q[1:0]];
`else
  assign blank_dig = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CONVERT;
          shift_d = in_value;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      CONVERT: begin
        {bcd_d, shift_d} = {bcd_adj[NUM_DIG-1][2:0], bcd_adj[NUM_DIG-2:0], shift_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          state_d = DRIVE;
          cnt_d   = '0;
        end
      end
      DRIVE: begin
        hex_d[cnt_q[1:0]] = blank_dig ? BLANK : seg_leds;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd3) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hex_q   <= {NUM_DIG{BLANK}};
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
    end
  end

  // decoder only ever sees a real digit during DRIVE, zero otherwise
  assign seg_val  = (state_q == DRIVE) ? {1'b0, cur_nib} : 5'd0;
  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hex0     = hex_q[0];
  assign hex1     = hex_q[1];
  assign hex2     = hex_q[2];
  assign hex3     = hex_q[3];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: stimulus queues expected digits, a monitor checks them on done.
module tb_hex_display_ctrl;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000,
                         S4 = 7'b0011001, S5 = 7'b0010010, S7 = 7'b1111000,
                         S9 = 7'b0010000, BL = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z = BL;
`else
  localparam logic [6:0] Z = S0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] in_value;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] seg_val;
  logic [6:0] seg_leds;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic       busy, done;

  hex_display_ctrl dut (
    .clk(clk), .reset(reset), .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .seg_val(seg_val), .seg_leds(seg_leds), .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // shared active-low seg7 decoder
  always_comb begin
    case (seg_val)
      5'd0: seg_leds = 7'b1000000;
      5'd1: seg_leds = 7'b1111001;
      5'd2: seg_leds = 7'b0100100;
      5'd3: seg_leds = 7'b0110000;
      5'd4: seg_leds = 7'b0011001;
      5'd5: seg_leds = 7'b0010010;
      5'd6: seg_leds = 7'b0000010;
      5'd7: seg_leds = 7'b1111000;
      5'd8: seg_leds = 7'b0000000;
      5'd9: seg_leds = 7'b0010000;
      default: seg_leds = 7'b1111111;
    endcase
  end

  typedef struct { logic [6:0] h3, h2, h1, h0; } exp_t;
  exp_t expq[$];

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // monitor: latency, busy span, digit values and seg_val range
  int  t_start = 0;
  int  busy_cnt = 0;
  bit  pend = 0;
  always @(negedge clk) begin
    chk("seg_val_range", 32'(seg_val <= 5'd9), 1);
    if (reset) begin
      pend = 0;
    end else begin
      if (pend && busy) busy_cnt++;
      if (done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("hex3", hex3, e.h3);
          chk("hex2", hex2, e.h2);
          chk("hex1", hex1, e.h1);
          chk("hex0", hex0, e.h0);
          chk("latency", cyc - t_start, 14);
          chk("busy_cycles", busy_cnt, 15);
        end
        pend = 0;
      end
      if (in_valid && in_ready) begin
        t_start  = cyc + 1;
        busy_cnt = 0;
        pend     = 1;
      end
    end
  end

  task automatic send(input logic [9:0] v, input logic [6:0] e3, e2, e1, e0,
                      input bit push, input bit hold);
    int n = 0;
    exp_t e;
    e = '{e3, e2, e1, e0};
    if (push) expq.push_back(e);
    in_value = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_ready", in_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_timeout", expq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_seg_val"}, seg_val, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with a simultaneous request: reset must win
    reset = 1'b1; in_valid = 1'b1; in_value = 10'd5;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    chk_idle("reset");
    chk("reset_hex", {hex3, hex2, hex1, hex0}, {4{BL}});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_prio_busy", busy, 0);

    send(10'd0,    Z,  Z,  Z,  S0, 1, 0); drain();
    send(10'd1023, S1, S0, S2, S3, 1, 0); drain();
    send(10'd42,   Z,  Z,  S4, S2, 1, 0); drain();
    send(10'd100,  Z,  S1, S0, S0, 1, 0); drain();
    send(10'd999,  Z,  S9, S9, S9, 1, 0); drain();
    send(10'd10,   Z,  Z,  S1, S0, 1, 0); drain();
    chk_idle("between");

    // back-to-back with in_valid held high; the 7 presented during the busy window is only taken at the second transfer
    begin
      int nbusy = 0;
      send(10'd5, Z, Z, Z, S5, 1, 1);
      in_value = 10'd7;
      expq.push_back('{Z, Z, Z, S7});
      @(negedge clk);
      while (!in_ready && nbusy < 40) begin
        nbusy++;
        @(negedge clk);
      end
      chk("b2b_gap", nbusy, 15);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain();
    end

    // abort: show 1023, then reset during the 4th CONVERT cycle of a new conversion
    send(10'd1023, S1, S0, S2, S3, 1, 0); drain();
    send(10'd5, Z, Z, Z, S5, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_idle("abort");
    chk("abort_hex", {hex3, hex2, hex1, hex0}, {4{BL}});
    repeat (25) @(posedge clk);
    #1;
    chk("abort_hex_hold", {hex3, hex2, hex1, hex0}, {4{BL}});
    chk_idle("abort_late");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
